// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared opcodes, ALU/operand encodings and sequencer states.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mc_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] F3_DWORD = 3'b011;
  localparam logic [2:0] F3_BEQ   = 3'b000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    WB_MEM = 4'd6,
    MEM_WR = 4'd7,
    BRANCH = 4'd8,
    TRAP   = 4'd9
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mc_decode.sv
// ============================================================================
// Module   : mc_decode
// Purpose  : Dispatch-state and legality decode of the latched instruction.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output state_t     dispatch,
  output state_t     mem_state,
  output logic       illegal
);

  always_comb begin
    dispatch = TRAP;
    case (opcode)
      OP_R:    dispatch = EXEC_R;
      OP_LD:   if (funct3 == F3_DWORD) dispatch = ADDR;
      OP_SD:   if (funct3 == F3_DWORD) dispatch = ADDR;
      OP_BEQ:  if (funct3 == F3_BEQ)   dispatch = BRANCH;
      default: dispatch = TRAP;
    endcase
    // Only legal ld/sd ever reach ADDR, so the opcode alone picks the direction.
    mem_state = (opcode == OP_LD) ? MEM_RD : MEM_WR;
    illegal   = (dispatch == TRAP);
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle fetch/decode/execute sequencer driving the ALU.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  input  logic             zero,
  output logic [31:0]      ir,
  output logic [1:0]       alu_op,
  output logic [3:0]       alu_cs,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             tgt_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  state_t            r_state;
  state_t            w_next;
  state_t            w_dispatch;
  state_t            w_mem_state;
  logic              w_illegal;
  logic [31:0]       r_ir;
  logic [CNT_W-1:0]  r_instret;
  logic              r_trap;
  logic              w_retire;
  logic              w_imem_req;
  logic              w_mem_req;
  logic              w_mem_we;
  logic              w_ir_we;
  logic              w_pc_we;
  logic              w_tgt_we;
  logic              w_rf_we;

  mc_decode u_decode (
    .opcode    (r_ir[6:0]),
    .funct3    (r_ir[14:12]),
    .dispatch  (w_dispatch),
    .mem_state (w_mem_state),
    .illegal   (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_ir      <= '0;
      r_instret <= '0;
      r_trap    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_we)                     r_ir      <= imem_rdata;
      if (w_retire)                    r_instret <= r_instret + CNT_W'(1);
      if (r_state == DECODE && w_illegal) r_trap <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_tgt_we   = 1'b0;
    w_rf_we    = 1'b0;
    w_retire   = 1'b0;
    pc_sel     = 1'b0;
    wb_sel     = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    case (r_state)
      FETCH: begin
        w_imem_req = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        if (imem_ack) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = DECODE;
        end
      end
      DECODE: begin
        // Branch target = oldPC + imm is captured here for every instruction.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        w_tgt_we  = 1'b1;
        w_next    = w_dispatch;
      end
      EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALUOP_FUNCT;
        w_next    = WB_R;
      end
      WB_R: begin
        alu_op   = ALUOP_FUNCT;
        w_rf_we  = 1'b1;
        w_retire = 1'b1;
        w_next   = FETCH;
      end
      ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        w_next    = w_mem_state;
      end
      MEM_RD: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        w_mem_req = 1'b1;
        if (mem_ack) w_next = WB_MEM;
      end
      WB_MEM: begin
        w_rf_we  = 1'b1;
        wb_sel   = 1'b1;
        w_retire = 1'b1;
        w_next   = FETCH;
      end
      MEM_WR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        if (mem_ack) begin
          w_retire = 1'b1;
          w_next   = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALUOP_SUB;
        pc_sel    = 1'b1;
        w_pc_we   = zero;
        w_retire  = 1'b1;
        w_next    = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = FETCH;
    endcase
  end

  // Strobes are masked combinationally so they drop in the very cycle rst_n falls.
  assign imem_req = rst_n & w_imem_req;
  assign mem_req  = rst_n & w_mem_req;
  assign mem_we   = rst_n & w_mem_we;
  assign ir_we    = rst_n & w_ir_we;
  assign pc_we    = rst_n & w_pc_we;
  assign tgt_we   = rst_n & w_tgt_we;
  assign rf_we    = rst_n & w_rf_we;

  assign ir      = r_ir;
  assign alu_cs  = {r_ir[30], r_ir[14:12]};
  assign instret = r_instret;
  assign trap    = r_trap;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Directed self-checking bench for the mc_ctrl sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mc_ctrl;

  localparam int CNT_W = 3;

  // obs = {imem_req, mem_req, mem_we, ir_we, pc_we, pc_sel, tgt_we, rf_we, wb_sel, trap,
  //        alu_op, alu_src_a, alu_src_b}
  localparam logic [15:0] E_RESET     = 16'b0000000000_00_00_01;
  localparam logic [15:0] E_FETCH     = 16'b1000000000_00_00_01;
  localparam logic [15:0] E_FETCH_ACK = 16'b1001100000_00_00_01;
  localparam logic [15:0] E_DECODE    = 16'b0000001000_00_10_10;
  localparam logic [15:0] E_EXEC_R    = 16'b0000000000_10_01_00;
  localparam logic [15:0] E_WB_R      = 16'b0000000100_10_00_00;
  localparam logic [15:0] E_ADDR      = 16'b0000000000_00_01_10;
  localparam logic [15:0] E_MEM_RD    = 16'b0100000000_00_01_10;
  localparam logic [15:0] E_WB_MEM    = 16'b0000000110_00_00_00;
  localparam logic [15:0] E_MEM_WR    = 16'b0110000000_00_01_10;
  localparam logic [15:0] E_BR_T      = 16'b0000110000_01_01_00;
  localparam logic [15:0] E_BR_NT     = 16'b0000010000_01_01_00;
  localparam logic [15:0] E_TRAP      = 16'b0000000001_00_00_00;
  localparam logic [15:0] E_MID_RST   = 16'b0000000000_00_01_10;
  localparam logic [15:0] E_TRAP_RST  = 16'b0000000001_00_00_00;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             imem_ack = 1'b0;
  logic [31:0]      imem_rdata = '0;
  logic             mem_ack = 1'b0;
  logic             zero = 1'b0;
  logic             imem_req, mem_req, mem_we;
  logic [31:0]      ir;
  logic [1:0]       alu_op, alu_src_a, alu_src_b;
  logic [3:0]       alu_cs;
  logic             ir_we, pc_we, pc_sel, tgt_we, rf_we, wb_sel, trap;
  logic [CNT_W-1:0] instret;
  logic [15:0]      obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs = {imem_req, mem_req, mem_we, ir_we, pc_we, pc_sel, tgt_we, rf_we, wb_sel, trap,
                alu_op, alu_src_a, alu_src_b};

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .zero       (zero),
    .ir         (ir),
    .alu_op     (alu_op),
    .alu_cs     (alu_cs),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .tgt_we     (tgt_we),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .instret    (instret),
    .trap       (trap)
  );

  task automatic test_reset;
    rst_n = 1'b0; imem_ack = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (obs !== E_RESET) begin errors++; $display("FAIL reset_obs cyc%0d got=%b exp=%b", i, obs, E_RESET); end
    end
    checks++; if (instret !== 3'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=0", ir); end
  endtask

  task automatic test_rtype(input logic [31:0] instr, input logic [3:0] cs, input logic [CNT_W-1:0] cnt);
    @(negedge clk); rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = instr; #1;
    checks++; if (obs !== E_FETCH_ACK) begin errors++; $display("FAIL r_fetch %h got=%b exp=%b", instr, obs, E_FETCH_ACK); end
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL r_decode got=%b exp=%b", obs, E_DECODE); end
    checks++; if (ir !== instr) begin errors++; $display("FAIL r_ir got=%h exp=%h", ir, instr); end
    @(negedge clk); #1;
    checks++; if (obs !== E_EXEC_R) begin errors++; $display("FAIL r_exec got=%b exp=%b", obs, E_EXEC_R); end
    checks++; if (alu_cs !== cs) begin errors++; $display("FAIL r_alu_cs got=%b exp=%b", alu_cs, cs); end
    @(negedge clk); #1;
    checks++; if (obs !== E_WB_R) begin errors++; $display("FAIL r_wb got=%b exp=%b", obs, E_WB_R); end
    @(negedge clk); #1;
    checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL r_refetch got=%b exp=%b", obs, E_FETCH); end
    checks++; if (instret !== cnt) begin errors++; $display("FAIL r_instret got=%0d exp=%0d", instret, cnt); end
  endtask

  task automatic test_ack_boundary;
    @(negedge clk); mem_ack = 1'b1; #1;
    checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL fetch_memack got=%b exp=%b", obs, E_FETCH); end
    @(negedge clk); #1;
    checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL fetch_memack_stay got=%b exp=%b", obs, E_FETCH); end
    mem_ack = 1'b0;
  endtask

  task automatic test_load;
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h0080B283; #1;
    checks++; if (obs !== E_FETCH_ACK) begin errors++; $display("FAIL ld_fetch got=%b exp=%b", obs, E_FETCH_ACK); end
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL ld_decode got=%b exp=%b", obs, E_DECODE); end
    @(negedge clk); #1;
    checks++; if (obs !== E_ADDR) begin errors++; $display("FAIL ld_addr got=%b exp=%b", obs, E_ADDR); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); imem_ack = (i == 0); imem_rdata = 32'hFFFFFFFF; mem_ack = (i == 3); #1;
      checks++; if (obs !== E_MEM_RD) begin errors++; $display("FAIL ld_memrd cyc%0d got=%b exp=%b", i, obs, E_MEM_RD); end
    end
    @(negedge clk); imem_ack = 1'b0; mem_ack = 1'b0; #1;
    checks++; if (obs !== E_WB_MEM) begin errors++; $display("FAIL ld_wb got=%b exp=%b", obs, E_WB_MEM); end
    checks++; if (ir !== 32'h0080B283) begin errors++; $display("FAIL ld_stray_ack_ir got=%h exp=0080b283", ir); end
    checks++; if (instret !== 3'd2) begin errors++; $display("FAIL ld_instret_early got=%0d exp=2", instret); end
    @(negedge clk); #1;
    checks++; if (instret !== 3'd3) begin errors++; $display("FAIL ld_instret got=%0d exp=3", instret); end
  endtask

  task automatic test_store;
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h0050B823; #1;
    checks++; if (obs !== E_FETCH_ACK) begin errors++; $display("FAIL sd_fetch got=%b exp=%b", obs, E_FETCH_ACK); end
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL sd_decode got=%b exp=%b", obs, E_DECODE); end
    @(negedge clk); #1;
    checks++; if (obs !== E_ADDR) begin errors++; $display("FAIL sd_addr got=%b exp=%b", obs, E_ADDR); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ack = (i == 1); #1;
      checks++; if (obs !== E_MEM_WR) begin errors++; $display("FAIL sd_memwr cyc%0d got=%b exp=%b", i, obs, E_MEM_WR); end
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL sd_refetch got=%b exp=%b", obs, E_FETCH); end
    checks++; if (instret !== 3'd4) begin errors++; $display("FAIL sd_instret got=%0d exp=4", instret); end
  endtask

  task automatic test_branch;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); zero = (k == 0); imem_ack = 1'b1; imem_rdata = 32'h00208063; #1;
      checks++; if (obs !== E_FETCH_ACK) begin errors++; $display("FAIL beq_fetch k%0d got=%b exp=%b", k, obs, E_FETCH_ACK); end
      @(negedge clk); imem_ack = 1'b0; #1;
      checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL beq_decode k%0d got=%b exp=%b", k, obs, E_DECODE); end
      @(negedge clk); #1;
      checks++; if (obs !== ((k == 0) ? E_BR_T : E_BR_NT)) begin errors++; $display("FAIL beq_branch k%0d got=%b exp=%b", k, obs, (k == 0) ? E_BR_T : E_BR_NT); end
      @(negedge clk); #1;
      checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL beq_refetch k%0d got=%b exp=%b", k, obs, E_FETCH); end
      checks++; if (instret !== CNT_W'(5 + k)) begin errors++; $display("FAIL beq_instret k%0d got=%0d exp=%0d", k, instret, 5 + k); end
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h002081B3; #1;
      checks++; if (obs !== E_FETCH_ACK) begin errors++; $display("FAIL b2b_fetch n%0d got=%b exp=%b", n, obs, E_FETCH_ACK); end
      checks++; if (instret !== ((n == 0) ? 3'd6 : 3'd7)) begin errors++; $display("FAIL b2b_instret n%0d got=%0d", n, instret); end
      @(negedge clk); #1;
      checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL b2b_decode n%0d got=%b exp=%b", n, obs, E_DECODE); end
      @(negedge clk); #1;
      @(negedge clk); #1;
      checks++; if (obs !== E_WB_R) begin errors++; $display("FAIL b2b_wb n%0d got=%b exp=%b", n, obs, E_WB_R); end
    end
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++; if (instret !== 3'd0) begin errors++; $display("FAIL b2b_wrap got=%0d exp=0", instret); end
    checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL b2b_refetch got=%b exp=%b", obs, E_FETCH); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h0080B283; #1;
    @(negedge clk); imem_ack = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (obs !== E_MEM_RD) begin errors++; $display("FAIL mid_memrd got=%b exp=%b", obs, E_MEM_RD); end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (obs !== E_MID_RST) begin errors++; $display("FAIL mid_rst_mask got=%b exp=%b", obs, E_MID_RST); end
    @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1; #1;
    checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL mid_refetch got=%b exp=%b", obs, E_FETCH); end
    checks++; if (ir !== 32'h0) begin errors++; $display("FAIL mid_ir got=%h exp=0", ir); end
    mem_ack = 1'b0;
  endtask

  task automatic test_trap;
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hFFFFFFFF; #1;
    checks++; if (obs !== E_FETCH_ACK) begin errors++; $display("FAIL trap_fetch got=%b exp=%b", obs, E_FETCH_ACK); end
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL trap_decode got=%b exp=%b", obs, E_DECODE); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); imem_ack = 1'b1; #1;
      checks++; if (obs !== E_TRAP) begin errors++; $display("FAIL trap_hold cyc%0d got=%b exp=%b", i, obs, E_TRAP); end
    end
    checks++; if (instret !== 3'd0) begin errors++; $display("FAIL trap_instret got=%0d exp=0", instret); end
    @(negedge clk); rst_n = 1'b0; imem_ack = 1'b0; #1;
    checks++; if (obs !== E_TRAP_RST) begin errors++; $display("FAIL trap_rst got=%b exp=%b", obs, E_TRAP_RST); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (obs !== E_FETCH) begin errors++; $display("FAIL trap_refetch got=%b exp=%b", obs, E_FETCH); end
  endtask

  initial begin
    test_reset();
    test_rtype(32'h002081B3, 4'b0000, 3'd1);
    test_rtype(32'h402081B3, 4'b1000, 3'd2);
    test_ack_boundary();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_reset_mid();
    test_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
